mainfsm_multicycle: RTL and testbench

//  Main control FSM for the multicycle ARM core: sequences one shared ALU/memory datapath through FETCH..WRITEBACK.

---
 rtl/mainfsm_multicycle.sv | 161 ++++++++++++++++
 tb/tb_mainfsm_multicycle.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mainfsm_multicycle.sv
// Main control FSM for the multicycle ARM core: steps the shared datapath through
// FETCH..WRITEBACK, stalls on MemReady and traps to a sticky fault on timeout or bad Op.
module mainfsm_multicycle #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State,
    output logic       Fault
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd15
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              fault_reg, fault_next;

    logic in_mem;
    logic timeout;
    logic irwrite_c, nextpc_c, regw_c, memw_c, branch_c;

    assign in_mem  = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    // A ready on the timeout cycle completes the access normally.
    assign timeout = in_mem && !MemReady && (wait_reg == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            wait_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        irwrite_c  = 1'b0;
        nextpc_c   = 1'b0;
        regw_c     = 1'b0;
        memw_c     = 1'b0;
        branch_c   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        case (state_reg)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    irwrite_c  = 1'b1;
                    nextpc_c   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = UNKNOWN;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady)     state_next = MEMWB;
                else if (timeout) state_next = UNKNOWN;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                regw_c     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memw_c = !timeout;
                if (MemReady)     state_next = FETCH;
                else if (timeout) state_next = UNKNOWN;
            end
            EXECR: begin
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: begin
                regw_c     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch_c   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = UNKNOWN;
        endcase
    end

    always_comb begin
        wait_next = '0;
        if (in_mem && !MemReady && (state_next == state_reg)) begin
            wait_next = (wait_reg == {WAIT_W{1'b1}}) ? wait_reg : wait_reg + 1'b1;
        end
    end

    assign fault_next = fault_reg || (state_next == UNKNOWN);

    // Raw enables are held off while reset is asserted.
    assign IRWrite = irwrite_c & ~reset;
    assign NextPC  = nextpc_c  & ~reset;
    assign RegW    = regw_c    & ~reset;
    assign MemW    = memw_c    & ~reset;
    assign Branch  = branch_c  & ~reset;
    assign State   = state_reg;
    assign Fault   = fault_reg;

endmodule

// File: tb/tb_mainfsm_multicycle.sv
// Self-checking bench for mainfsm_multicycle: vector table plus hand-written stall,
// timeout, undefined-Op and reset sequences, checked through an expected-value queue.
module tb_mainfsm_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, Fault;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    always #5 clk = ~clk;

    mainfsm_multicycle #(.MAX_WAIT(3), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .State(State), .Fault(Fault)
    );

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Fault}
    logic [12:0] act_ctl;
    assign act_ctl = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Fault};

    localparam logic [12:0] C_FETCH_RDY = 13'b1_0_1_10_10_0_1_0_0_0_0;
    localparam logic [12:0] C_FETCH_STL = 13'b0_0_1_10_10_0_0_0_0_0_0;
    localparam logic [12:0] C_DECODE    = 13'b0_0_1_10_10_0_0_0_0_0_0;
    localparam logic [12:0] C_MEMADR    = 13'b0_0_0_01_00_0_0_0_0_0_0;
    localparam logic [12:0] C_MEMRD     = 13'b0_1_0_00_00_0_0_0_0_0_0;
    localparam logic [12:0] C_MEMWB     = 13'b0_0_0_00_01_0_0_1_0_0_0;
    localparam logic [12:0] C_MEMWR     = 13'b0_1_0_00_00_0_0_0_1_0_0;
    localparam logic [12:0] C_MEMWR_TO  = 13'b0_1_0_00_00_0_0_0_0_0_0;
    localparam logic [12:0] C_EXECR     = 13'b0_0_0_00_00_1_0_0_0_0_0;
    localparam logic [12:0] C_EXECI     = 13'b0_0_0_01_00_1_0_0_0_0_0;
    localparam logic [12:0] C_ALUWB     = 13'b0_0_0_00_00_0_0_1_0_0_0;
    localparam logic [12:0] C_BRANCH    = 13'b0_0_0_01_10_0_0_0_0_1_0;
    localparam logic [12:0] C_UNK       = 13'b0_0_0_00_00_0_0_0_0_0_1;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        mr;
        logic [3:0]  st;
        logic [12:0] ctl;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [12:0] ctl;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    task automatic add_vec(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                           input logic mr, input logic [3:0] st, input logic [12:0] ctl);
        vec_t v;
        v.rst = rst; v.op = op; v.funct = funct; v.mr = mr; v.st = st; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs just after the edge and queue what the DUT must show.
    task automatic step(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                        input logic mr, input logic [3:0] st, input logic [12:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; Op = op; Funct = funct; MemReady = mr;
        e.st = st; e.ctl = ctl; e.idx = n_step;
        sb.push_back(e);
        n_step++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (State !== e.st) begin
                n_fail++;
                $display("FAIL state step %0d: got %0d expected %0d", e.idx, State, e.st);
            end
            n_tests++;
            if (act_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl step %0d (state %0d): got %b expected %b", e.idx, State, act_ctl, e.ctl);
            end
            $display("[TB] step %0d rst=%0b Op=%b Funct=%b MemReady=%0b State=%0d ctl=%b",
                     e.idx, reset, Op, Funct, MemReady, State, act_ctl);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset row checks enable forcing while FETCH sees MemReady=1.
        add_vec(1, 2'b00, 6'b000100, 1, 4'd0, C_FETCH_STL);
        // ADD register
        add_vec(0, 2'b00, 6'b000100, 1, 4'd0, C_FETCH_RDY);
        add_vec(0, 2'b00, 6'b000100, 1, 4'd1, C_DECODE);
        add_vec(0, 2'b00, 6'b000100, 1, 4'd6, C_EXECR);
        add_vec(0, 2'b00, 6'b000100, 1, 4'd8, C_ALUWB);
        // STR, no stall
        add_vec(0, 2'b01, 6'b011000, 1, 4'd0, C_FETCH_RDY);
        add_vec(0, 2'b01, 6'b011000, 1, 4'd1, C_DECODE);
        add_vec(0, 2'b01, 6'b011000, 1, 4'd2, C_MEMADR);
        add_vec(0, 2'b01, 6'b011000, 1, 4'd5, C_MEMWR);
        // B
        add_vec(0, 2'b10, 6'b000000, 1, 4'd0, C_FETCH_RDY);
        add_vec(0, 2'b10, 6'b000000, 1, 4'd1, C_DECODE);
        add_vec(0, 2'b10, 6'b000000, 1, 4'd9, C_BRANCH);
        // Data-processing immediate, don't-care Funct bits set
        add_vec(0, 2'b00, 6'b111110, 1, 4'd0, C_FETCH_RDY);
        add_vec(0, 2'b00, 6'b111110, 1, 4'd1, C_DECODE);
        add_vec(0, 2'b00, 6'b111110, 0, 4'd7, C_EXECI);
        add_vec(0, 2'b00, 6'b111110, 0, 4'd8, C_ALUWB);

        reset = 1'b1; Op = 2'b00; Funct = 6'b0; MemReady = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].mr, tbl[i].st, tbl[i].ctl);

        // LDR: three stalls in MEMRD, ready arrives exactly when the counter hits MAX_WAIT.
        step(0, 2'b01, 6'b011001, 1, 4'd0, C_FETCH_RDY);
        step(0, 2'b01, 6'b011001, 1, 4'd1, C_DECODE);
        step(0, 2'b01, 6'b011001, 1, 4'd2, C_MEMADR);
        for (int i = 0; i < 3; i++)
            step(0, 2'b01, 6'b011001, 0, 4'd3, C_MEMRD);
        step(0, 2'b01, 6'b011001, 1, 4'd3, C_MEMRD);
        step(0, 2'b01, 6'b011001, 1, 4'd4, C_MEMWB);

        // FETCH timeout: four stall edges then UNKNOWN, late MemReady ignored.
        for (int i = 0; i < 4; i++)
            step(0, 2'b00, 6'b000000, 0, 4'd0, C_FETCH_STL);
        step(0, 2'b00, 6'b000000, 1, 4'd15, C_UNK);
        step(1, 2'b00, 6'b000000, 0, 4'd15, C_UNK);
        // Counter restarts from 0 after reset: three stalls do not trap.
        for (int i = 0; i < 3; i++)
            step(0, 2'b00, 6'b000000, 0, 4'd0, C_FETCH_STL);
        step(0, 2'b00, 6'b000000, 1, 4'd0, C_FETCH_RDY);
        step(0, 2'b00, 6'b000000, 1, 4'd1, C_DECODE);
        step(0, 2'b00, 6'b000000, 1, 4'd6, C_EXECR);
        step(0, 2'b00, 6'b000000, 1, 4'd8, C_ALUWB);

        // STR timeout: MemW drops on the timeout cycle.
        step(0, 2'b01, 6'b000000, 1, 4'd0, C_FETCH_RDY);
        step(0, 2'b01, 6'b000000, 1, 4'd1, C_DECODE);
        step(0, 2'b01, 6'b000000, 1, 4'd2, C_MEMADR);
        for (int i = 0; i < 3; i++)
            step(0, 2'b01, 6'b000000, 0, 4'd5, C_MEMWR);
        step(0, 2'b01, 6'b000000, 0, 4'd5, C_MEMWR_TO);
        step(0, 2'b01, 6'b000000, 0, 4'd15, C_UNK);
        step(1, 2'b01, 6'b000000, 0, 4'd15, C_UNK);

        // Undefined Op traps and stays put for ten cycles.
        step(0, 2'b11, 6'b000000, 1, 4'd0, C_FETCH_RDY);
        step(0, 2'b11, 6'b000000, 1, 4'd1, C_DECODE);
        for (int i = 0; i < 10; i++)
            step(0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'(i % 2), 4'd15, C_UNK);
        step(1, 2'b00, 6'b000000, 1, 4'd15, C_UNK);

        // Reset mid-LDR stall.
        step(0, 2'b01, 6'b000001, 1, 4'd0, C_FETCH_RDY);
        step(0, 2'b01, 6'b000001, 1, 4'd1, C_DECODE);
        step(0, 2'b01, 6'b000001, 1, 4'd2, C_MEMADR);
        step(0, 2'b01, 6'b000001, 0, 4'd3, C_MEMRD);
        step(1, 2'b01, 6'b000001, 0, 4'd3, C_MEMRD);
        step(0, 2'b01, 6'b000001, 0, 4'd0, C_FETCH_STL);
        step(0, 2'b01, 6'b000001, 1, 4'd0, C_FETCH_RDY);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
